// File: rtl/jtframe_ioctl_feed.sv
// Streams a ROM image byte by byte from a variable-latency source into the ioctl
// download port, pacing writes and holding the window until the SDRAM path is idle.
module jtframe_ioctl_feed #(
   parameter int AW   = 26,
   parameter int GAP  = 8,
   parameter int TAIL = 16
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] rom_len,
   output logic [AW-1:0] rom_addr,
   output logic          rom_cs,
   input  logic          rom_ok,
   input  logic [7:0]    rom_data,
   output logic          downloading,
   output logic [AW-1:0] ioctl_addr,
   output logic [7:0]    ioctl_dout,
   output logic          ioctl_wr,
   input  logic          dwnld_busy,
   output logic          done,
   output logic [AW-1:0] sent
);

   localparam int CMAX = (GAP > TAIL) ? GAP : TAIL;
   localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
   localparam logic [CW-1:0] TAIL_LAST = CW'(TAIL - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_WRITE, ST_GAP, ST_TAIL, ST_DRAIN, ST_DONE
   } state_t;

   state_t        st, st_nx;
   logic [AW-1:0] len;
   logic [CW-1:0] cnt;
   logic          got;        // byte captured; FETCH spends one more cycle before WRITE
   logic          drain_arm;  // game has seen downloading low for a full cycle

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st <= ST_IDLE;
      else     st <= st_nx;
   end

   always_comb begin
      st_nx = st;
      case (st)
         ST_IDLE, ST_DONE:
            if (start) st_nx = (rom_len == '0) ? ST_DONE : ST_FETCH;
         ST_FETCH:
            if (got) st_nx = ST_WRITE;
         ST_WRITE:
            st_nx = ST_GAP;
         ST_GAP:
            if (cnt == GAP_LAST) st_nx = (sent < len) ? ST_FETCH : ST_TAIL;
         ST_TAIL:
            if (cnt == TAIL_LAST) st_nx = ST_DRAIN;
         ST_DRAIN:
            if (drain_arm && !dwnld_busy) st_nx = ST_DONE;
         default:
            st_nx = ST_IDLE;
      endcase
   end

   // Outputs decode the state register only, so no input reaches an output
   // combinationally and reset clears every strobe immediately.
   always_comb begin
      rom_cs      = (st == ST_FETCH) && !got;
      ioctl_wr    = (st == ST_WRITE);
      downloading = (st == ST_FETCH) || (st == ST_WRITE) ||
                    (st == ST_GAP)   || (st == ST_TAIL);
      done        = (st == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len        <= '0;
         sent       <= '0;
         rom_addr   <= '0;
         ioctl_addr <= '0;
         ioctl_dout <= '0;
         cnt        <= '0;
         got        <= 1'b0;
         drain_arm  <= 1'b0;
      end else begin
         case (st)
            ST_IDLE, ST_DONE:
               if (start) begin
                  len       <= rom_len;
                  sent      <= '0;
                  rom_addr  <= '0;
                  cnt       <= '0;
                  got       <= 1'b0;
                  drain_arm <= 1'b0;
               end
            ST_FETCH:
               if (!got && rom_ok) begin
                  ioctl_dout <= rom_data;
                  ioctl_addr <= rom_addr;
                  got        <= 1'b1;
               end
            ST_WRITE: begin
               got      <= 1'b0;
               cnt      <= '0;
               sent     <= sent + 1'b1;
               rom_addr <= rom_addr + 1'b1;
            end
            ST_GAP:
               cnt <= (cnt == GAP_LAST) ? '0 : cnt + 1'b1;
            ST_TAIL: begin
               cnt       <= (cnt == TAIL_LAST) ? '0 : cnt + 1'b1;
               drain_arm <= 1'b0;
            end
            ST_DRAIN:
               drain_arm <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jtframe_ioctl_feed.sv
// Directed/randomised bench for jtframe_ioctl_feed: a latency-randomised byte source,
// a strobe monitor, and expected writes computed from the ROM image and the pacing rules.
module tb_jtframe_ioctl_feed;
   localparam int AW = 26, GAP = 8, TAIL = 16;

   logic          clk, rst, start, rom_cs, rom_ok, downloading, ioctl_wr, dwnld_busy, done;
   logic [AW-1:0] rom_len, rom_addr, ioctl_addr, sent;
   logic [7:0]    rom_data, ioctl_dout;

   jtframe_ioctl_feed #(.AW(AW), .GAP(GAP), .TAIL(TAIL)) dut (
      .clk(clk), .rst(rst), .start(start), .rom_len(rom_len), .rom_addr(rom_addr),
      .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data), .downloading(downloading),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
      .dwnld_busy(dwnld_busy), .done(done), .sent(sent)
   );

   int n_assert = 0, n_fail = 0, cyc = 0;
   logic [7:0]    mem [0:1023];
   int            lat_lo = 1, lat_hi = 1;
   logic [AW-1:0] obs_addr [$];
   logic [7:0]    obs_data [$];
   int            obs_cyc  [$];
   int            wr_cs_bad, fall_cyc;
   logic          dl_seen, dl_prev = 1'b0;

   initial begin clk = 1'b0; forever #5 clk = ~clk; end
   initial forever begin @(posedge clk); cyc++; end

   // Byte source: rom_ok after a random number of cycles with rom_cs held
   initial begin
      int wcnt, lat;
      wcnt = 0; lat = 1; rom_ok = 1'b0; rom_data = 8'h00;
      forever begin
         @(negedge clk);
         if (rom_cs && wcnt >= lat) begin
            rom_ok = 1'b1; rom_data = mem[rom_addr[9:0]];
         end else if (rom_cs) begin
            rom_ok = 1'b0; rom_data = 8'($urandom); wcnt++;
         end else begin
            rom_ok = 1'b0; rom_data = 8'($urandom); wcnt = 0;
            lat = int'($urandom_range(lat_hi, lat_lo));
         end
      end
   end

   // Strobe / window monitor
   initial forever begin
      @(negedge clk);
      if (ioctl_wr) begin
         obs_addr.push_back(ioctl_addr); obs_data.push_back(ioctl_dout); obs_cyc.push_back(cyc);
         if (rom_cs) wr_cs_bad++;
      end
      if (downloading) dl_seen = 1'b1;
      if (dl_prev && !downloading) fall_cyc = cyc;
      dl_prev = downloading;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
      wr_cs_bad = 0; fall_cyc = -1; dl_seen = 1'b0;
   endtask

   task automatic pulse_start(input logic [AW-1:0] len);
      @(negedge clk); start = 1'b1; rom_len = len;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!done && k < budget) begin @(negedge clk); k++; end
      check("done_timeout", done, 1'b1);
   endtask

   // Expected image: byte i at address i, data taken from the source array
   task automatic check_writes(input string tag, input int n, input int period);
      check({tag, "_count"}, obs_addr.size(), n);
      for (int i = 0; i < n && i < obs_addr.size(); i++) begin
         check({tag, "_addr"}, obs_addr[i], i);
         check({tag, "_data"}, obs_data[i], mem[i]);
         if (period > 0 && i > 0) check({tag, "_period"}, obs_cyc[i] - obs_cyc[i-1], period);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; rom_len = '0; dwnld_busy = 1'b0;
      foreach (mem[i]) mem[i] = 8'($urandom);
      clear_mon();
      #3;
      check("rst_outs", {rom_cs, ioctl_wr, downloading, done}, 4'b0);
      check("rst_sent", sent, 0);
      check("rst_addr", {rom_addr, ioctl_addr, ioctl_dout}, 0);
      @(negedge clk); @(negedge clk); rst = 1'b0;

      // 1: four bytes, one-cycle source latency
      mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
      lat_lo = 1; lat_hi = 1; clear_mon();
      pulse_start(4);
      check("t1_dl_on", downloading, 1'b1);
      wait_done(2000);
      check_writes("t1", 4, GAP + 4);
      if (obs_cyc.size() == 4) check("t1_tail", fall_cyc, obs_cyc[3] + GAP + TAIL + 1);
      check("t1_sent", sent, 4);
      check("t1_dl_off", downloading, 1'b0);

      // zero-latency source gives the peak rate
      lat_lo = 0; lat_hi = 0; clear_mon();
      pulse_start(3);
      wait_done(2000);
      check_writes("t1b", 3, GAP + 3);

      // 2: 256 bytes, random latency 1..20
      foreach (mem[i]) mem[i] = 8'($urandom);
      lat_lo = 1; lat_hi = 20; clear_mon();
      pulse_start(256);
      wait_done(20000);
      check_writes("t2", 256, 0);
      check("t2_wr_cs", wr_cs_bad, 0);
      check("t2_sent", sent, 256);

      // 3: SDRAM path busy for 100 cycles after the window closes
      lat_lo = 1; lat_hi = 1; clear_mon(); dwnld_busy = 1'b1;
      pulse_start(2);
      for (int k = 0; k < 2000 && fall_cyc < 0; k++) @(negedge clk);
      check("t3_fell", fall_cyc >= 0, 1'b1);
      for (int k = 0; k < 200 && cyc < fall_cyc + 100; k++) @(negedge clk);
      check("t3_done_early", done, 1'b0);
      dwnld_busy = 1'b0;
      @(negedge clk);
      check("t3_done_rise", done, 1'b1);

      // 4: start during byte 2 ignored; start in DONE restarts
      clear_mon();
      pulse_start(4);
      for (int k = 0; k < 500 && obs_addr.size() < 2; k++) @(negedge clk);
      pulse_start(9);
      wait_done(2000);
      check_writes("t4", 4, 0);
      check("t4_sent", sent, 4);
      clear_mon();
      pulse_start(3);
      check("t4_restart_sent", sent, 0);
      check("t4_restart_flags", {done, downloading}, 2'b01);
      wait_done(2000);
      check_writes("t4r", 3, 0);
      check("t4r_sent", sent, 3);

      // 5: asynchronous reset while the write strobe is high
      clear_mon();
      pulse_start(8);
      for (int k = 0; k < 500 && !ioctl_wr; k++) @(negedge clk);
      check("t5_in_write", ioctl_wr, 1'b1);
      #2 rst = 1'b1;
      #1 check("t5_rst_outs", {ioctl_wr, downloading, done, rom_cs}, 4'b0);
      check("t5_rst_sent", sent, 0);
      @(negedge clk); rst = 1'b0;
      clear_mon();
      pulse_start(3);
      wait_done(2000);
      check_writes("t5", 3, 0);

      // 6: zero-length load
      clear_mon();
      pulse_start(0);
      check("t6_done", done, 1'b1);
      check("t6_sent", sent, 0);
      repeat (5) @(negedge clk);
      check("t6_no_wr", obs_addr.size(), 0);
      check("t6_no_dl", dl_seen, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
